// File: rtl/calc_seq_param.sv
// Switch/button calculator: two W-bit operands, add/sub/mul and a W-cycle restoring divide, with overflow and divide-by-zero flags.
// Buttons are 2-FF synchronised and act on release; CALC_DEBOUNCE_EN adds a DEB_CYCLES debouncer. Events arriving while busy are dropped.
module calc_seq_param #(
  parameter int W          = 16,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         CLK100MHZ,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         btnC,
  input  logic         btnL,
  input  logic         btnR,
  input  logic         btnD,
  input  logic         btnU,
  output logic [W-1:0] LED,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, READY, DIV, SHOW} state_t;

  // Button vector order doubles as priority: bit 4 (C) wins over bit 0 (L).
  logic [4:0] w_btn;
  logic [4:0] r_sync1, r_sync2, r_lvl_d;
  logic [4:0] w_lvl, w_evt;

  assign w_btn = {btnC, btnU, btnD, btnR, btnL};

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl_d <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  logic [4:0]     r_deb;
  logic [DCW-1:0] r_dcnt [5];

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < 5; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
            r_deb[i]  <= r_sync2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DCW'(1);
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync2;
  // DEB_CYCLES has no role without the debouncer.
  if (DEB_CYCLES < 1) begin : g_deb_cycles_unused
  end
`endif

  assign w_evt = r_lvl_d & ~w_lvl;

  state_t         r_state, w_state;
  logic [W-1:0]   r_n1, r_n2, r_led, r_rem, r_quo;
  logic [W-1:0]   w_n1, w_n2, w_led, w_rem, w_quo;
  logic           r_ovf, r_err, r_busy, w_ovf, w_err, w_busy;
  logic [CW-1:0]  r_cnt, w_cnt;

  logic [W:0]     w_sum, w_part, w_diff;
  logic [W-1:0]   w_sub, w_rem_step, w_quo_step;
  logic [2*W-1:0] w_prod;
  logic           w_ge;

  assign w_sum  = {1'b0, r_n1} + {1'b0, r_n2};
  assign w_sub  = r_n1 - r_n2;
  assign w_prod = (2*W)'(r_n1) * (2*W)'(r_n2);

  // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  assign w_part     = {r_rem, r_quo[W-1]};
  assign w_ge       = w_part >= {1'b0, r_n2};
  assign w_diff     = w_part - {1'b0, r_n2};
  assign w_rem_step = w_ge ? w_diff[W-1:0] : w_part[W-1:0];
  assign w_quo_step = {r_quo[W-2:0], w_ge};

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_n1    <= '0;
      r_n2    <= '0;
      r_led   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_n1    <= w_n1;
      r_n2    <= w_n2;
      r_led   <= w_led;
      r_ovf   <= w_ovf;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_rem   <= w_rem;
      r_quo   <= w_quo;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_n1    = r_n1;
    w_n2    = r_n2;
    w_led   = r_led;
    w_ovf   = r_ovf;
    w_err   = r_err;
    w_busy  = r_busy;
    w_rem   = r_rem;
    w_quo   = r_quo;
    w_cnt   = r_cnt;
    case (r_state)
      ENTER_A: begin
        if (w_evt[4]) begin
          w_n1    = sw;
          w_led   = sw;
          w_err   = 1'b0;
          w_ovf   = 1'b0;
          w_state = ENTER_B;
        end
      end
      ENTER_B: begin
        if (w_evt[4]) begin
          w_n2    = sw;
          w_led   = sw;
          w_state = READY;
        end
      end
      READY, SHOW: begin
        if (w_evt[4]) begin
          w_n1    = sw;
          w_led   = sw;
          w_err   = 1'b0;
          w_ovf   = 1'b0;
          w_state = ENTER_B;
        end else if (w_evt[3]) begin
          w_ovf = 1'b0;
          if (r_n2 == '0) begin
            w_led   = '1;
            w_err   = 1'b1;
            w_state = ENTER_A;
          end else begin
            w_busy  = 1'b1;
            w_rem   = '0;
            w_quo   = r_n1;
            w_cnt   = '0;
            w_state = DIV;
          end
        end else if (w_evt[2]) begin
          w_led   = w_prod[W-1:0];
          w_ovf   = |w_prod[2*W-1:W];
          w_state = SHOW;
        end else if (w_evt[1]) begin
          w_led   = w_sub;
          w_ovf   = r_n1 < r_n2;
          w_state = SHOW;
        end else if (w_evt[0]) begin
          w_led   = w_sum[W-1:0];
          w_ovf   = w_sum[W];
          w_state = SHOW;
        end
      end
      DIV: begin
        w_rem = w_rem_step;
        w_quo = w_quo_step;
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(W - 1)) begin
          w_led   = w_quo_step;
          w_busy  = 1'b0;
          w_state = SHOW;
        end
      end
      default: w_state = ENTER_A;
    endcase
  end

  assign LED  = r_led;
  assign ovf  = r_ovf;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_calc_seq_param.sv
// Directed plus randomised bench for calc_seq_param against an operand-count reference model.
module tb_calc_seq_param;

  localparam int W      = 16;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;
  localparam int SETTLE = 14;
  localparam longint unsigned MOD = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [4:0]   btn;
  logic [W-1:0] led;
  logic         ovf, err, busy;

  calc_seq_param #(.W(W), .DEB_CYCLES(DEB)) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .sw       (sw),
    .btnC     (btn[4]),
    .btnL     (btn[0]),
    .btnR     (btn[1]),
    .btnD     (btn[2]),
    .btnU     (btn[3]),
    .LED      (led),
    .ovf      (ovf),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: how many operands are held (0..2) replaces the FSM.
  longint unsigned m_n1, m_n2, m_led;
  logic            m_ovf, m_err;
  int              m_have;

  function automatic void model_reset();
    m_n1 = 0; m_n2 = 0; m_led = 0; m_ovf = 1'b0; m_err = 1'b0; m_have = 0;
  endfunction

  function automatic void model_apply(input logic [4:0] m, input logic [W-1:0] s);
    longint unsigned p;
    int b;
    b = -1;
    for (int i = 0; i < 5; i++) if (m[i]) b = i;
    if (b == 4) begin
      if (m_have == 1) begin
        m_n2 = s; m_led = s; m_have = 2;
      end else begin
        m_n1 = s; m_led = s; m_err = 1'b0; m_ovf = 1'b0; m_have = 1;
      end
    end else if (b >= 0 && m_have == 2) begin
      case (b)
        0: begin p = m_n1 + m_n2; m_led = p % MOD; m_ovf = (p >= MOD); end
        1: begin m_led = (m_n1 + MOD - m_n2) % MOD; m_ovf = (m_n1 < m_n2); end
        2: begin p = m_n1 * m_n2; m_led = p % MOD; m_ovf = (p >= MOD); end
        default: begin
          m_ovf = 1'b0;
          if (m_n2 == 0) begin
            m_led = MOD - 1; m_err = 1'b1; m_have = 0;
          end else begin
            m_led = m_n1 / m_n2;
          end
        end
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".led"},  32'(led),  32'(m_led));
    chk({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
    chk({tag, ".err"},  32'(err),  32'(m_err));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    btn = m;
    repeat (HOLD) @(negedge clk);
    btn = '0;
    repeat (SETTLE) @(negedge clk);
    if (busy) begin
      for (int i = 0; i < 64 && busy; i++) @(negedge clk);
      chk("busy_timeout", 32'(busy), 32'd0);
      @(negedge clk);
    end
    model_apply(m, sw);
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    sw = a; press(5'b10000);
    sw = b; press(5'b10000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [4:0]   m;
    int           bcnt;

    rst = 1'b1; sw = '0; btn = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.led",  32'(led),  32'd0);
    chk("rst.ovf",  32'(ovf),  32'd0);
    chk("rst.err",  32'(err),  32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load(16'h0007, 16'h0003);
    check_model("loadB");
    chk("loadB.const", 32'(led), 32'h0003);
    press(5'b00001); check_model("add");
    chk("add.const", 32'(led), 32'h000A);
    press(5'b00010); check_model("sub");
    chk("sub.const", 32'(led), 32'h0004);
    load(16'h0002, 16'h0005);
    press(5'b00010); check_model("sub_neg");
    chk("sub_neg.const", 32'(led), 32'hFFFD);
    load(16'h0100, 16'h0100);
    press(5'b00100); check_model("mul_ovf");
    load(16'h00FF, 16'h0002);
    press(5'b00100); check_model("mul");
    chk("mul.const", 32'(led), 32'h01FE);

    // Divide 100/7 with an L press landing mid-division.
    load(16'h0064, 16'h0007);
    @(negedge clk);
    btn = 5'b01000;
    repeat (HOLD) @(negedge clk);
    btn = '0;
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
        if (bcnt == 1) btn[0] = 1'b1;
        if (bcnt == 7) btn[0] = 1'b0;
      end
    end
    btn = '0;
    model_apply(5'b01000, sw);
    chk("div.busy_cycles", 32'(bcnt), 32'd16);
    check_model("div");
    chk("div.const", 32'(led), 32'h000E);

    load(16'h0055, 16'h0000);
    press(5'b01000); check_model("div0");
    chk("div0.err", 32'(err), 32'd1);
    press(5'b00001); check_model("div0_L_ignored");
    sw = 16'h0005; press(5'b10000); check_model("div0_clear");
    sw = 16'h0006; press(5'b10000);

    // L and C released together in READY: C alone acts.
    sw = 16'h1234; press(5'b10001); check_model("C_beats_L");
    press(5'b00001); check_model("enterB_L_ignored");
    sw = 16'h0001; press(5'b10000);
    press(5'b00001); check_model("after_prio");

    // Reset during division.
    load(16'hFFFF, 16'h0003);
    @(negedge clk);
    btn = 5'b01000;
    repeat (HOLD) @(negedge clk);
    btn = '0;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    chk("rstdiv.started", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstdiv.led",  32'(led),  32'd0);
    chk("rstdiv.busy", 32'(busy), 32'd0);
    chk("rstdiv.err",  32'(err),  32'd0);
    chk("rstdiv.ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

`ifdef CALC_DEBOUNCE_EN
    sw = 16'h0ABC;
    for (int i = 0; i < 5; i++) begin
      btn[4] = 1'b1; repeat (2) @(negedge clk);
      btn[4] = 1'b0; repeat (2) @(negedge clk);
    end
    btn[4] = 1'b1; repeat (8) @(negedge clk);
    btn[4] = 1'b0; repeat (SETTLE) @(negedge clk);
    model_apply(5'b10000, sw);
    check_model("bounce_one_load");
    sw = 16'h0011; press(5'b00001); check_model("bounce_L_ignored");
    press(5'b10000);
    press(5'b00001); check_model("bounce_sum");
`endif

    for (int it = 0; it < 24; it++) begin
      a = W'($urandom);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      load(a, b);
      m = 5'(1) << $urandom_range(0, 3);
      press(m);
      check_model($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_seq_param.md
Name: calc_seq_param

Overview:
- Parametrised successor of the board-level switch/button calculator.
- Two W-bit operands are entered from the switches with the centre button.
- Four operations run on button release: add, subtract, multiply, divide. Division is a multi-cycle restoring divider.
- Adds proper input synchronisation, debouncing, an explicit entry FSM, and overflow / divide-by-zero status. Sits directly between board I/O and the LED bank.

Parameters:
- W, 16, operand and result width in bits (>=2).
- DEB_CYCLES, 1000000, consecutive stable samples before a button level is accepted (10 ms at 100 MHz).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- rst  input  1  asynchronous active-high reset
- sw  input  W  operand switches
- btnC  input  1  load operand (A, then B)
- btnL  input  1  add
- btnR  input  1  subtract
- btnD  input  1  multiply
- btnU  input  1  divide
- LED  output  W  displayed operand/result, registered
- ovf  output  1  result did not fit in W bits
- err  output  1  divide by zero occurred
- busy  output  1  divider running

Behaviour:
- Reset (async, rst=1): LED=0, ovf=0, err=0, busy=0, n1=n2=0, state=ENTER_A, all sync/debounce registers cleared.
- Input conditioning:
  - Each button passes through a 2-FF synchroniser, then the debouncer.
  - Debounced level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive clocks; any mismatch-free sample resets the counter.
  - An event is a 1-cycle pulse on the debounced falling edge (release).
- Event priority, same cycle: C > U > D > R > L. Lower-priority events in that cycle are discarded.
- FSM states: ENTER_A, ENTER_B, READY, DIV, SHOW.
- ENTER_A:
  - C: n1<=sw, LED<=sw, err<=0, ovf<=0 -> ENTER_B.
  - Op events ignored.
- ENTER_B:
  - C: n2<=sw, LED<=sw -> READY.
  - Op events ignored.
- READY / SHOW:
  - C: n1<=sw, LED<=sw, err<=0, ovf<=0 -> ENTER_B (new entry).
  - L: LED<=(n1+n2) mod 2^W, ovf<=carry-out -> SHOW.
  - R: LED<=(n1-n2) mod 2^W, ovf<=(n1<n2) -> SHOW.
  - D: LED<=low W bits of n1*n2, ovf<=(upper W bits != 0) -> SHOW.
  - U with n2==0: LED<=all ones, err<=1, ovf<=0 -> ENTER_A.
  - U with n2!=0: busy<=1, ovf<=0 -> DIV.
  - Latency for L/R/D and divide-by-zero: LED updated on the clock after the event pulse.
  - Operands are kept, so repeated ops on the same n1/n2 are allowed.
- DIV:
  - Unsigned restoring division, one quotient bit per clock, exactly W clocks.
  - Then LED<=quotient, busy<=0 -> SHOW.
  - busy is high for exactly W cycles.
  - All events ignored (dropped, not queued) while busy.
- Arithmetic is unsigned. Operands are latched at C. sw changes after latching have no effect.
- Reset mid-division: aborts immediately, all outputs return to reset values.

Optional Feature:
- CALC_DEBOUNCE_EN defined: debouncer as described.
- Not defined: debouncer removed; the event is the falling edge of the 2-FF synchronised level, and DEB_CYCLES is unused. Used for fast simulation.

Test Plan:
- W=16, DEB_CYCLES=4: rst; sw=0x0007, press/release C; sw=0x0003, press/release C; press/release L -> LED=0x000A, ovf=0, state SHOW.
- Same operands, R -> LED=0x0004. Then reload n1=0x0002, n2=0x0005, R -> LED=0xFFFD, ovf=1.
- n1=0x0100, n2=0x0100, D -> LED=0x0000, ovf=1. n1=0x00FF, n2=0x0002, D -> LED=0x01FE, ovf=0.
- n1=0x0064, n2=0x0007, U:
  - busy high exactly 16 cycles, then LED=0x000E.
  - L pressed during busy is ignored.
  - n2=0 then U -> LED=0xFFFF, err=1, state ENTER_A. Next C clears err.
- Bounce: btnC toggles every 2 cycles for 20 cycles, then stays high >4 cycles, then low -> exactly one load (debounce build only).
- Assert rst during DIV -> LED=0, busy=0, err=0, ovf=0 asynchronously. L and C pulsed in the same cycle in READY -> only C acts.
